// File: rtl/cpu_pkg.sv
// Shared datapath definitions: op encoding, mul/div FSM states and iteration counter sizing.
package cpu_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH itself, the cycle that performs the sign fix.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement negation; used for operand magnitudes and the final sign fix.
module abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result_c
);

  assign result_c = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit feeding the Z-high/Z-low registers.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_q, sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   mag_a, mag_b, dividend_q;
  logic [2*WIDTH-1:0] acc, acc_nxt_c;

  logic [WIDTH-1:0]   abs_a_c, abs_b_c, quot_c, rem_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH+1:0]   trial_c;
  logic               accept_c, finish_c;

  abs_neg #(.WIDTH(WIDTH)) u_abs_a (.value(operand_a), .negate(operand_a[WIDTH-1]), .result_c(abs_a_c));
  abs_neg #(.WIDTH(WIDTH)) u_abs_b (.value(operand_b), .negate(operand_b[WIDTH-1]), .result_c(abs_b_c));

  // Result sign fix: product/quotient follow sign(a)^sign(b), remainder follows the dividend.
  abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .negate(sign_a_q ^ sign_b_q), .result_c(prod_c));
  abs_neg #(.WIDTH(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .negate(sign_a_q ^ sign_b_q), .result_c(quot_c));
  abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(sign_a_q), .result_c(rem_c));

  assign accept_c = (state == IDLE) && start;
  assign finish_c = (state == RUN) && (cnt == CW'(WIDTH));

  // One iteration: acc = {partial product | remainder, multiplier | quotient bits}
  always_comb begin
    mul_sum_c = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    trial_c   = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mag_b};
    acc_nxt_c = acc;
    if (op_q == OP_DIV) begin
      if (trial_c[WIDTH+1])
        acc_nxt_c = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_nxt_c = {trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt_c = {mul_sum_c, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      op_q        <= OP_MUL;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      dividend_q  <= '0;
      acc         <= '0;
    end else begin
      state <= state_nxt;
      done  <= finish_c;
      if (accept_c) begin
        busy       <= 1'b1;
        cnt        <= '0;
        op_q       <= op;
        sign_a_q   <= operand_a[WIDTH-1];
        sign_b_q   <= operand_b[WIDTH-1];
        mag_a      <= abs_a_c;
        mag_b      <= abs_b_c;
        dividend_q <= operand_a;
        acc        <= {{WIDTH{1'b0}}, (op == OP_DIV) ? abs_a_c : abs_b_c};
      end else if (finish_c) begin
        busy <= 1'b0;
        cnt  <= '0;
        if (op_q == OP_DIV && mag_b == '0) begin
          result_hi   <= dividend_q;
          result_lo   <= '1;
          div_by_zero <= 1'b1;
        end else if (op_q == OP_DIV) begin
          result_hi   <= rem_c;
          result_lo   <= quot_c;
          div_by_zero <= 1'b0;
        end else begin
          result_hi   <= prod_c[2*WIDTH-1:WIDTH];
          result_lo   <= prod_c[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        acc <= acc_nxt_c;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random and directed ops against an arithmetic reference model.
module tb_mul_div_unit;
  import cpu_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic          clock = 1'b0;
  logic          clear, start, op;
  logic [W-1:0]  operand_a, operand_b;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  result_hi, result_lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic [W-1:0] hold_hi = '0, hold_lo = '0;
  logic         hold_dz = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed arithmetic with the two documented special cases.
  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      p;
    logic [63:0] pv;
    int          sa, sbv;
    e.dz  = 1'b0;
    e.cyc = 0;
    if (o == OP_MUL) begin
      p    = longint'($signed(a)) * longint'($signed(b));
      pv   = p;
      e.hi = pv[63:32];
      e.lo = pv[31:0];
    end else if (b == 0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'h0;
      e.lo = 32'h8000_0000;
    end else begin
      sa   = a;
      sbv  = b;
      e.lo = sa / sbv;
      e.hi = sa % sbv;
    end
    return e;
  endfunction

  // Monitor: pops on done, and checks the result ports hold steady while busy.
  always @(negedge clock) begin
    if (!clear) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("result_hi", 64'(result_hi), 64'(mon_e.hi));
          check("result_lo", 64'(result_lo), 64'(mon_e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
          check("latency", 64'(cyc - mon_e.cyc), 64'(LAT));
          check("busy_at_done", 64'(busy), 64'(0));
          hold_hi = mon_e.hi;
          hold_lo = mon_e.lo;
          hold_dz = mon_e.dz;
        end
      end else if (busy) begin
        check("hold_result", {result_hi, result_lo}, {hold_hi, hold_lo});
        check("hold_dz", 64'(div_by_zero), 64'(hold_dz));
      end
    end
  end

  task automatic push_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e     = model(o, a, b);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clock);
    while ((busy || done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle at cycle %0d", cyc);
      return;
    end
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock);
    #1;
    push_exp(o, a, b);
    check("busy_after_accept", 64'(busy), 64'(1));
    start = 1'b0; op = 1'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         ro;
    int           n;

    clear = 1'b1; start = 1'b0; op = OP_MUL; operand_a = '0; operand_b = '0;
    #2;
    check("reset_results", {result_hi, result_lo}, 64'(0));
    check("reset_flags", 64'({busy, done, div_by_zero}), 64'(0));
    @(posedge clock);
    start = 1'b1; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clock);
    #1;
    check("start_during_clear", 64'(busy), 64'(0));
    @(negedge clock);
    start = 1'b0; clear = 1'b0;

    // Directed corner cases
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    issue(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    issue(OP_DIV, 32'hFFFF_FFEF, 32'd5);
    issue(OP_DIV, 32'h0000_1234, 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    drain();

    // start during RUN must be ignored
    issue(OP_MUL, 32'd12345, 32'hFFFF_FC19);
    repeat (10) @(negedge clock);
    start = 1'b1; op = OP_DIV; operand_a = 32'd99; operand_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    drain();

    // start held through DONE: refused in the done cycle, accepted in the following IDLE cycle
    issue(OP_DIV, 32'd1000, 32'd7);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    start = 1'b1; op = OP_MUL; operand_a = 32'hFFFF_FFFF; operand_b = 32'h7FFF_FFFF;
    @(posedge clock);
    #1;
    check("start_in_done_cycle", 64'(busy), 64'(0));
    @(posedge clock);
    #1;
    push_exp(OP_MUL, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    check("back_to_back_accept", 64'(busy), 64'(1));
    start = 1'b0;
    drain();

    // clear mid-operation discards the in-flight op
    issue(OP_MUL, 32'd55, 32'd66);
    repeat (20) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check("clear_results", {result_hi, result_lo}, 64'(0));
    check("clear_flags", 64'({busy, done, div_by_zero}), 64'(0));
    sb.delete();
    hold_hi = '0; hold_lo = '0; hold_dz = 1'b0;
    @(posedge clock);
    start = 1'b1; op = OP_DIV; operand_a = 32'd8; operand_b = 32'd2;
    #1;
    check("start_during_clear2", 64'(busy), 64'(0));
    @(negedge clock);
    clear = 1'b0; start = 1'b0;
    repeat (40) @(negedge clock);
    check("no_done_after_clear", 64'(busy), 64'(0));
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    drain();

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(0, 15)) - 32'd8;
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      issue(ro, ra, rb);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
